// File: rtl/burst_control_unit_if.sv
// Memory handshake bundle between the burst control unit and the
// instruction/data memories.
interface burst_control_unit_if;
    logic imem_ready;
    logic dmem_ready;
    logic mem_read;
    logic mem_write;

    modport master (
        input  imem_ready,
        input  dmem_ready,
        output mem_read,
        output mem_write
    );

    modport slave (
        output imem_ready,
        output dmem_ready,
        input  mem_read,
        input  mem_write
    );
endinterface

// File: rtl/burst_control_unit.sv
// Multicycle control FSM with memory ready handshakes, N-beat LDW/SDW
// bursts and a trap state for illegal opcodes and register-file faults.
module burst_control_unit #(
    parameter int OPW        = 6,
    parameter int WIDE_BEATS = 2,
    parameter int BEAT_W     = $clog2(WIDE_BEATS),
    parameter bit TRAP_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPW-1:0]       opcode,
    input  logic                 zero,
    input  logic                 positive,
    input  logic                 negative,
    input  logic                 exception,
    burst_control_unit_if.master mem,
    output logic                 pc_write,
    output logic                 reg_read,
    output logic                 reg_write,
    output logic                 reg_write_addr_sel,
    output logic                 mem_to_reg,
    output logic [BEAT_W-1:0]    beat_idx,
    output logic                 branch,
    output logic                 jump,
    output logic                 jr,
    output logic [1:0]           alu_op,
    output logic                 alu_src_b,
    output logic                 stall,
    output logic                 trap,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEMORY     = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_TRAP       = 3'd5
    } state_t;

    localparam int XW = OPW + 5;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WIDE_BEATS - 1);

    state_t            state_q;
    state_t            next_state;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;

    logic [XW-1:0] op_ext;
    logic          illegal;
    logic [15:0]   op;
    logic          is_wide;
    logic          exc_trap;

    // Zero-extend so the >=16 test works for any OPW without slicing.
    assign op_ext   = XW'(opcode);
    assign illegal  = (op_ext >= XW'(16));
    assign op       = illegal ? 16'd0 : (16'd1 << opcode[3:0]);
    assign is_wide  = op[8] | op[9];
    assign exc_trap = TRAP_EN && is_wide && exception;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= next_state;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        next_state         = S_FETCH;
        beat_d             = '0;
        pc_write           = 1'b0;
        reg_read           = 1'b0;
        reg_write          = 1'b0;
        reg_write_addr_sel = 1'b0;
        mem.mem_read       = 1'b0;
        mem.mem_write      = 1'b0;
        mem_to_reg         = 1'b0;
        branch             = 1'b0;
        jump               = 1'b0;
        jr                 = 1'b0;
        alu_op             = 2'b00;
        alu_src_b          = 1'b0;
        stall              = 1'b0;
        trap               = 1'b0;

        case (state_q)
            S_FETCH: begin
                pc_write   = mem.imem_ready;
                next_state = mem.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                reg_read = 1'b1;
                stall    = is_wide;
                if (illegal)
                    next_state = TRAP_EN ? S_TRAP : S_FETCH;
                else
                    next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (op[1] | op[5] | op[6] | op[7] | op[8] | op[9] |
                    op[13] | op[14] | op[15])
                    alu_op = 2'b01;
                if (op[2])
                    alu_op = 2'b10;
                if (op[3] | op[10] | op[11] | op[12])
                    alu_op = 2'b11;
                alu_src_b = |op[9:4];
                branch    = (op[10] & zero) | (op[11] & positive) |
                            (op[12] & negative);
                jump      = op[14] | op[15];
                jr        = op[13];
                if (|op[9:6])
                    next_state = S_MEMORY;
                else if (|op[14:10])
                    next_state = S_FETCH;
                else
                    next_state = S_WRITE_BACK;
            end
            S_MEMORY: begin
                stall = is_wide;
                // A fault aborts the beat before any request leaves.
                if (exc_trap) begin
                    next_state = S_TRAP;
                end else begin
                    mem.mem_read  = op[6] | op[8];
                    mem.mem_write = op[7] | op[9];
                    beat_d        = beat_q;
                    next_state    = S_MEMORY;
                    if (mem.dmem_ready) begin
                        if (is_wide) begin
                            reg_write  = op[8];
                            mem_to_reg = op[8];
                            if (beat_q == LAST_BEAT) begin
                                beat_d     = '0;
                                next_state = S_FETCH;
                            end else begin
                                beat_d = beat_q + BEAT_W'(1);
                            end
                        end else begin
                            beat_d     = '0;
                            next_state = op[6] ? S_WRITE_BACK : S_FETCH;
                        end
                    end
                end
            end
            S_WRITE_BACK: begin
                reg_write          = (|op[6:0]) | op[15];
                mem_to_reg         = op[6];
                reg_write_addr_sel = op[15];
            end
            S_TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (reset) begin
            next_state         = S_FETCH;
            beat_d             = '0;
            pc_write           = 1'b0;
            reg_read           = 1'b0;
            reg_write          = 1'b0;
            reg_write_addr_sel = 1'b0;
            mem.mem_read       = 1'b0;
            mem.mem_write      = 1'b0;
            mem_to_reg         = 1'b0;
            branch             = 1'b0;
            jump               = 1'b0;
            jr                 = 1'b0;
            alu_op             = 2'b00;
            alu_src_b          = 1'b0;
            stall              = 1'b0;
            trap               = 1'b0;
        end
    end

    assign state_o  = reset ? 3'd0 : state_q;
    assign beat_idx = reset ? '0 : beat_q;

endmodule

// File: tb/tb_burst_control_unit.sv
// Directed bench: a 4-beat trapping instance and a 2-beat non-trapping one.
module tb_burst_control_unit;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2;
    localparam logic [2:0] SM = 3'd3, SW = 3'd4, ST = 3'd5;

    localparam logic [14:0] PCW = 15'h4000, RR  = 15'h2000;
    localparam logic [14:0] RW  = 15'h1000, SEL = 15'h0800;
    localparam logic [14:0] MR  = 15'h0400, MW  = 15'h0200;
    localparam logic [14:0] M2R = 15'h0100, BR  = 15'h0080;
    localparam logic [14:0] JMP = 15'h0040, JRB = 15'h0020;
    localparam logic [14:0] ADD = 15'h0008, SUB = 15'h0010;
    localparam logic [14:0] CMP = 15'h0018, SRB = 15'h0004;
    localparam logic [14:0] STL = 15'h0002, TRP = 15'h0001;

    logic clk;
    logic reset;
    logic [5:0] opcode;
    logic zero, positive, negative, exception;

    logic pw_a, rr_a, rw_a, sel_a, m2r_a, br_a, j_a, jr_a;
    logic srcb_a, stl_a, trp_a;
    logic [1:0] alu_a;
    logic [1:0] bi_a;
    logic [2:0] st_a;

    logic pw_b, rr_b, rw_b, sel_b, m2r_b, br_b, j_b, jr_b;
    logic srcb_b, stl_b, trp_b;
    logic [1:0] alu_b;
    logic [0:0] bi_b;
    logic [2:0] st_b;

    burst_control_unit_if ifa ();
    burst_control_unit_if ifb ();

    int checks = 0;
    int errors = 0;
    int pulses;
    logic [19:0] exp_a;
    logic [18:0] exp_b;
    logic [19:0] obs_a;
    logic [18:0] obs_b;

    burst_control_unit #(.OPW(6), .WIDE_BEATS(4), .TRAP_EN(1'b1)) u_a (
        .clk(clk), .reset(reset), .opcode(opcode),
        .zero(zero), .positive(positive), .negative(negative),
        .exception(exception), .mem(ifa),
        .pc_write(pw_a), .reg_read(rr_a), .reg_write(rw_a),
        .reg_write_addr_sel(sel_a), .mem_to_reg(m2r_a),
        .beat_idx(bi_a), .branch(br_a), .jump(j_a), .jr(jr_a),
        .alu_op(alu_a), .alu_src_b(srcb_a), .stall(stl_a),
        .trap(trp_a), .state_o(st_a)
    );

    burst_control_unit #(.OPW(6), .WIDE_BEATS(2), .TRAP_EN(1'b0)) u_b (
        .clk(clk), .reset(reset), .opcode(opcode),
        .zero(zero), .positive(positive), .negative(negative),
        .exception(exception), .mem(ifb),
        .pc_write(pw_b), .reg_read(rr_b), .reg_write(rw_b),
        .reg_write_addr_sel(sel_b), .mem_to_reg(m2r_b),
        .beat_idx(bi_b), .branch(br_b), .jump(j_b), .jr(jr_b),
        .alu_op(alu_b), .alu_src_b(srcb_b), .stall(stl_b),
        .trap(trp_b), .state_o(st_b)
    );

    assign obs_a = {st_a, bi_a, pw_a, rr_a, rw_a, sel_a,
                    ifa.mem_read, ifa.mem_write, m2r_a, br_a, j_a, jr_a,
                    alu_a, srcb_a, stl_a, trp_a};
    assign obs_b = {st_b, bi_b, pw_b, rr_b, rw_b, sel_b,
                    ifb.mem_read, ifb.mem_write, m2r_b, br_b, j_b, jr_b,
                    alu_b, srcb_b, stl_b, trp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        opcode = 6'd1;
        ifa.imem_ready = 1'b1;
        ifb.imem_ready = 1'b1;
        cyc();
        cyc();
        #1; checks++;
        if (obs_a !== 20'd0) begin
            errors++;
            $display("FAIL reset_a: got %h want %h", obs_a, 20'd0);
        end
        checks++;
        if (obs_b !== 19'd0) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", obs_b, 19'd0);
        end
        ifb.imem_ready = 1'b0;
        reset = 1'b0;
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL reset_exit: got %h want %h", obs_a, exp_a);
        end
    endtask

    task automatic test_add;
        opcode = 6'd1;
        cyc();
        exp_a = {SD, 2'd0, RR};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL add_decode: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exp_a = {SE, 2'd0, ADD};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL add_exec: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exp_a = {SW, 2'd0, RW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL add_wb: got %h want %h", obs_a, exp_a);
        end
        cyc();
        opcode = 6'd6;
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL add_fetch: got %h want %h", obs_a, exp_a);
        end
    endtask

    task automatic test_lw;
        ifa.dmem_ready = 1'b0;
        cyc();
        cyc();
        exp_a = {SE, 2'd0, ADD | SRB};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL lw_exec: got %h want %h", obs_a, exp_a);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            ifa.dmem_ready = (k == 2);
            exp_a = {SM, 2'd0, MR};
            #1; checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL lw_mem%0d: got %h want %h", k, obs_a, exp_a);
            end
        end
        cyc();
        ifa.dmem_ready = 1'b0;
        exp_a = {SW, 2'd0, RW | M2R};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL lw_wb: got %h want %h", obs_a, exp_a);
        end
        cyc();
        opcode = 6'd8;
    endtask

    task automatic test_ldw_burst;
        cyc();
        exp_a = {SD, 2'd0, RR | STL};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL ldw_decode: got %h want %h", obs_a, exp_a);
        end
        cyc();
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            ifa.dmem_ready = (k % 2 == 0);
            if (k % 2 == 0)
                exp_a = {SM, 2'((k + 1) / 2), MR | RW | M2R | STL};
            else
                exp_a = {SM, 2'((k + 1) / 2), MR | STL};
            #1; checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL ldw_beat%0d: got %h want %h", k, obs_a, exp_a);
            end
            if (rw_a === 1'b1)
                pulses++;
        end
        cyc();
        ifa.dmem_ready = 1'b0;
        opcode = 6'd9;
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL ldw_done: got %h want %h", obs_a, exp_a);
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL ldw_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_sdw_exception;
        cyc();
        cyc();
        cyc();
        ifa.dmem_ready = 1'b1;
        exp_a = {SM, 2'd0, MW | STL};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL sdw_beat0: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exception = 1'b1;
        exp_a = {SM, 2'd1, STL};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL sdw_exc: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exception = 1'b0;
        ifa.dmem_ready = 1'b0;
        exp_a = {ST, 2'd0, PCW | TRP};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL sdw_trap: got %h want %h", obs_a, exp_a);
        end
        cyc();
        opcode = 6'd20;
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL sdw_fetch: got %h want %h", obs_a, exp_a);
        end
    endtask

    task automatic test_illegal;
        cyc();
        exp_a = {SD, 2'd0, RR};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL ill_decode_a: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exp_a = {ST, 2'd0, PCW | TRP};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL ill_trap_a: got %h want %h", obs_a, exp_a);
        end
        cyc();
        ifa.imem_ready = 1'b0;
        ifb.imem_ready = 1'b1;
        exp_b = {SF, 1'b0, PCW};
        #1; checks++;
        if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL ill_fetch_b: got %h want %h", obs_b, exp_b);
        end
        cyc();
        exp_b = {SD, 1'b0, RR};
        #1; checks++;
        if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL ill_decode_b: got %h want %h", obs_b, exp_b);
        end
        checks++;
        if (obs_a !== 20'd0) begin
            errors++;
            $display("FAIL ill_idle_a: got %h want %h", obs_a, 20'd0);
        end
        cyc();
        ifb.imem_ready = 1'b0;
        exp_b = {SF, 1'b0, 15'd0};
        #1; checks++;
        if (obs_b !== exp_b) begin
            errors++;
            $display("FAIL ill_back_b: got %h want %h", obs_b, exp_b);
        end
        ifa.imem_ready = 1'b1;
        opcode = 6'd8;
    endtask

    task automatic test_reset_mid_burst;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            ifa.dmem_ready = (k % 2 == 0);
        end
        cyc();
        ifa.dmem_ready = 1'b1;
        exp_a = {SM, 2'd2, MR | RW | M2R | STL};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL mid_beat2: got %h want %h", obs_a, exp_a);
        end
        reset = 1'b1;
        #1; checks++;
        if (obs_a !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", obs_a, 20'd0);
        end
        cyc();
        reset = 1'b0;
        ifa.dmem_ready = 1'b0;
        opcode = 6'd10;
        zero = 1'b0;
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL mid_after: got %h want %h", obs_a, exp_a);
        end
        cyc();
        cyc();
        exp_a = {SE, 2'd0, CMP};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL bz_nottaken: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exp_a = {SF, 2'd0, PCW};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL bz_fetch: got %h want %h", obs_a, exp_a);
        end
    endtask

    task automatic test_branch_jump;
        zero = 1'b1;
        cyc();
        cyc();
        exp_a = {SE, 2'd0, CMP | BR};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL bz_taken: got %h want %h", obs_a, exp_a);
        end
        cyc();
        zero = 1'b0;
        opcode = 6'd15;
        cyc();
        cyc();
        exp_a = {SE, 2'd0, ADD | JMP};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL cll_exec: got %h want %h", obs_a, exp_a);
        end
        cyc();
        exp_a = {SW, 2'd0, RW | SEL};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL cll_wb: got %h want %h", obs_a, exp_a);
        end
        cyc();
        opcode = 6'd2;
        cyc();
        cyc();
        exp_a = {SE, 2'd0, SUB};
        #1; checks++;
        if (obs_a !== exp_a) begin
            errors++;
            $display("FAIL sub_exec: got %h want %h", obs_a, exp_a);
        end
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'd0;
        zero = 1'b0;
        positive = 1'b0;
        negative = 1'b0;
        exception = 1'b0;
        ifa.imem_ready = 1'b0;
        ifa.dmem_ready = 1'b0;
        ifb.imem_ready = 1'b0;
        ifb.dmem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw();
        test_ldw_burst();
        test_sdw_exception();
        test_illegal();
        test_reset_mid_burst();
        test_branch_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_control_unit.md
Name: burst_control_unit

Overview:
- Parametrised successor to the processor's multicycle control FSM.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITE_BACK for the existing 16-opcode ISA.
- Adds ready/wait handshakes on instruction and data memory.
- Generalises the double-word ops (LDW/SDW) to an N-beat burst with a beat counter.
- Adds a TRAP state for illegal opcodes and register-file exceptions. Sits between the instruction register and the datapath muxes/ALU/memories.

Parameters:
OPW, 6, opcode width; opcodes 0..15 legal, all values >=16 illegal.
WIDE_BEATS, 2, number of beats for opcodes 8 (LDW) and 9 (SDW); legal range 2..16.
BEAT_W, $clog2(WIDE_BEATS), width of beat_idx (WIDE_BEATS>=2 guarantees >=1).
TRAP_EN, 1, 1 = illegal opcode/exception enter TRAP; 0 = illegal opcode treated as NOP, exception ignored.

Ports:
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
opcode  in  OPW  current instruction opcode (stable from DECODE until FETCH).
zero  in  1  ALU zero flag (BZ).
positive  in  1  ALU positive flag (BGZ).
negative  in  1  ALU negative flag (BLZ).
exception  in  1  register-file exception.
imem_ready  in  1  instruction memory data valid.
dmem_ready  in  1  data memory accepted/returned current access.
pc_write  out  1  PC update enable.
reg_read  out  1  register read enable.
reg_write  out  1  register write enable.
reg_write_addr_sel  out  1  select R14 as destination (CLL).
mem_read  out  1  data read request.
mem_write  out  1  data write request.
mem_to_reg  out  1  write-back data from memory.
beat_idx  out  BEAT_W  current burst beat; datapath adds it to address and register index.
branch  out  1  taken conditional branch.
jump  out  1  J/CLL.
jr  out  1  JR.
alu_op  out  2  00 OR, 01 ADD, 10 SUB, 11 CMP.
alu_src_b  out  1  select immediate.
stall  out  1  block next fetch during bursts.
trap  out  1  trap taken; PC source becomes trap vector.
state_o  out  3  current state (debug).

Behaviour:
- Encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITE_BACK=4, TRAP=5; codes 6-7 go to FETCH next cycle with all outputs 0.
- Reset: synchronous, active-high. Next edge: state=FETCH, beat_idx=0. While reset is high, every output is forced to 0, including state_o=0.
- Reset mid-operation: aborts immediately, with no further mem_read/mem_write/reg_write.
- All outputs except state_o and beat_idx are combinational decodes of state/opcode/flags. Unlisted outputs are 0.
- FETCH: waits while imem_ready=0, all outputs 0. pc_write=1 only in the cycle imem_ready=1, then -> DECODE.
- DECODE:
  - reg_read=1; stall=1 for opcodes 8/9.
  - Opcode >=16 with TRAP_EN=1 -> TRAP.
  - Opcode >=16 with TRAP_EN=0 -> FETCH.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - alu_op: 00 for 0,4; 01 for 1,5,6,7,8,9,13,14,15; 10 for 2; 11 for 3,10,11,12.
  - alu_src_b=1 for 4..9.
  - branch=(op10&zero)|(op11&positive)|(op12&negative); jump=op14|op15; jr=op13.
  - Next state: ops 6-9 -> MEMORY; ops 10-14 -> FETCH; all others -> WRITE_BACK.
- MEMORY:
  - mem_read=op6|op8; mem_write=op7|op9; held stable until dmem_ready=1.
  - LW (op 6): on ready -> WRITE_BACK.
  - SW (op 7): on ready -> FETCH; no write-back.
  - LDW/SDW (ops 8/9):
    - stall=1 every cycle.
    - LDW asserts reg_write=1 and mem_to_reg=1 in each ready cycle (one register per beat).
    - On ready, beat_idx increments. On ready with beat_idx==WIDE_BEATS-1: beat_idx<=0 and -> FETCH.
  - Exception check (TRAP_EN=1): exception=1 in any MEMORY cycle of op 8/9 -> TRAP. The same cycle's mem_read/mem_write/reg_write is suppressed, and beat_idx<=0.
  - Exception and dmem_ready high in the same cycle: exception wins.
- WRITE_BACK:
  - reg_write=1 for ops 0-6 excluding 5? No: ops 0,1,2,3,4,5,6 and 15.
  - mem_to_reg=op6; reg_write_addr_sel=op15.
  - -> FETCH.
- TRAP: one cycle; trap=1, pc_write=1, stall=0 -> FETCH. Writes already completed by earlier beats are not undone.
- beat_idx is only nonzero inside MEMORY for ops 8/9.

Test Plan:
- ADD (op 1), imem_ready=1 -> states 0,1,2,4,0; reg_write=1 in cycle 4 only; alu_op=01 in EXECUTE; 4 cycles per instruction.
- LW (op 6), dmem_ready low 2 cycles -> mem_read held 3 cycles, beat_idx=0, then WRITE_BACK with reg_write=1, mem_to_reg=1.
- WIDE_BEATS=4, LDW (op 8), dmem_ready alternating 1/0 -> beat_idx 0,1,2,3; 4 reg_write pulses; stall=1 through MEMORY; returns to FETCH.
- SDW, exception=1 at beat_idx=1 -> no mem_write that cycle, TRAP next cycle with trap=1 and pc_write=1, then FETCH with beat_idx=0.
- Opcode 20 (TRAP_EN=1) -> DECODE then TRAP then FETCH. Same opcode with TRAP_EN=0 -> DECODE then FETCH with trap=0.
- reset=1 during LDW beat 2 -> all outputs 0 immediately; next edge state_o=0 and beat_idx=0; BZ with zero=0 afterwards gives branch=0 and returns to FETCH.
